// File: rtl/tmr_pkg.sv
// Shared encodings, register map and helpers for the 8-bit timer channel.
package tmr_pkg;

    localparam logic [2:0] ADDR_TCR   = 3'd0;
    localparam logic [2:0] ADDR_TCSR  = 3'd1;
    localparam logic [2:0] ADDR_TCORA = 3'd2;
    localparam logic [2:0] ADDR_TCORB = 3'd3;
    localparam logic [2:0] ADDR_TCNT  = 3'd4;

    typedef enum logic [2:0] {
        CKS_STOP     = 3'b000,
        CKS_DIV8     = 3'b001,
        CKS_DIV64    = 3'b010,
        CKS_DIV8192  = 3'b011,
        CKS_EXT_RISE = 3'b100,
        CKS_EXT_FALL = 3'b101,
        CKS_EXT_BOTH = 3'b110,
        CKS_STOP_ALT = 3'b111
    } cks_e;

    typedef enum logic [1:0] {
        CCLR_NONE    = 2'b00,
        CCLR_MATCH_A = 2'b01,
        CCLR_MATCH_B = 2'b10,
        CCLR_EXT     = 2'b11
    } cclr_e;

    typedef enum logic [1:0] {
        OS_NONE   = 2'b00,
        OS_LOW    = 2'b01,
        OS_HIGH   = 2'b10,
        OS_TOGGLE = 2'b11
    } os_e;

    localparam int TCR_CMIEB    = 7;
    localparam int TCR_CMIEA    = 6;
    localparam int TCR_OVIE     = 5;
    localparam int TCR_CCLR_LSB = 3;
    localparam int TCR_CKS_LSB  = 0;

    localparam int TCSR_CMFB    = 7;
    localparam int TCSR_CMFA    = 6;
    localparam int TCSR_OVF     = 5;
    localparam int TCSR_OSB_LSB = 2;
    localparam int TCSR_OSA_LSB = 0;

    localparam int DIV_EXP_0 = 3;
    localparam int DIV_EXP_1 = 6;
    localparam int DIV_EXP_2 = 13;

    function automatic int div_exp(input int idx);
        case (idx)
            0:       return DIV_EXP_0;
            1:       return DIV_EXP_1;
            default: return DIV_EXP_2;
        endcase
    endfunction

    // Coincident A/B matches resolve as toggle > high > low.
    function automatic logic tmo_resolve(input logic cur, input logic ma, input logic mb,
                                         input os_e osa, input os_e osb);
        os_e eff;
        eff = OS_NONE;
        if (ma && mb) begin
            if (osa == OS_TOGGLE || osb == OS_TOGGLE)
                eff = OS_TOGGLE;
            else if (osa == OS_HIGH || osb == OS_HIGH)
                eff = OS_HIGH;
            else if (osa == OS_LOW || osb == OS_LOW)
                eff = OS_LOW;
        end else if (ma) begin
            eff = osa;
        end else if (mb) begin
            eff = osb;
        end
        case (eff)
            OS_LOW:    return 1'b0;
            OS_HIGH:   return 1'b1;
            OS_TOGGLE: return ~cur;
            default:   return cur;
        endcase
    endfunction

endpackage

// File: rtl/tmr_input_sync.sv
// Two-flop synchronizer for an asynchronous pin plus one-cycle rise/fall pulses.
module tmr_input_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic meta_reg;
    logic sync_reg;
    logic prev_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_reg <= 1'b0;
            sync_reg <= 1'b0;
            prev_reg <= 1'b0;
        end else begin
            meta_reg <= din;
            sync_reg <= meta_reg;
            prev_reg <= sync_reg;
        end
    end

    assign rise = sync_reg & ~prev_reg;
    assign fall = ~sync_reg & prev_reg;

endmodule

// File: rtl/tmr_channel_ctrl.sv
// One 8-bit timer channel: register file, count-clock select, clear policy,
// compare/overflow flags, TMO output and interrupt requests.
module tmr_channel_ctrl
    import tmr_pkg::*;
#(
    parameter int BIT_WIDTH   = 8,
    parameter int PRESC_WIDTH = 13
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2:0]           addr,
    input  logic                 wr,
    input  logic                 rd,
    input  logic [BIT_WIDTH-1:0] wdata,
    output logic [BIT_WIDTH-1:0] rdata,
    input  logic                 tmci,
    input  logic                 tmri,
    output logic                 tmo,
    output logic                 irq_cma,
    output logic                 irq_cmb,
    output logic                 irq_ovf
);

    logic [BIT_WIDTH-1:0]   tcnt_reg;
    logic [BIT_WIDTH-1:0]   tcnt_next;
    logic [BIT_WIDTH-1:0]   tcora_reg;
    logic [BIT_WIDTH-1:0]   tcorb_reg;
    logic [BIT_WIDTH-1:0]   tcr_reg;
    logic [BIT_WIDTH-1:0]   rdata_reg;
    logic [BIT_WIDTH-1:0]   rd_sel;
    logic [7:0]             tcsr_view;
    os_e                    osa_reg;
    os_e                    osb_reg;
    logic [PRESC_WIDTH-1:0] presc_reg;
    logic [2:0]             div_tick;
    logic [2:0]             flags;
    logic [2:0]             set_vec;
    logic                   tmo_reg;
    logic                   tick;
    logic                   match_a;
    logic                   match_b;
    logic                   ovf_evt;
    logic                   ci_rise;
    logic                   ci_fall;
    logic                   ri_rise;
    logic                   tmri_fall_unused;
    logic                   wr_tcsr;
    logic                   rd_tcsr;
    cks_e                   cks;
    cclr_e                  cclr;

    genvar gi;

    tmr_input_sync u_tmci_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (tmci),
        .rise (ci_rise),
        .fall (ci_fall)
    );

    tmr_input_sync u_tmri_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (tmri),
        .rise (ri_rise),
        .fall (tmri_fall_unused)
    );

    always_ff @(posedge clk) begin
        if (rst)
            presc_reg <= '0;
        else
            presc_reg <= presc_reg + 1'b1;
    end

    for (gi = 0; gi < 3; gi++) begin : g_div
        localparam int EXP = div_exp(gi);
        assign div_tick[gi] = &presc_reg[EXP-1:0];
    end

    assign cks     = cks_e'(tcr_reg[TCR_CKS_LSB +: 3]);
    assign cclr    = cclr_e'(tcr_reg[TCR_CCLR_LSB +: 2]);
    assign wr_tcsr = wr && (addr == ADDR_TCSR);
    assign rd_tcsr = rd && (addr == ADDR_TCSR);

    always_comb begin
        tick = 1'b0;
        case (cks)
            CKS_DIV8:     tick = div_tick[0];
            CKS_DIV64:    tick = div_tick[1];
            CKS_DIV8192:  tick = div_tick[2];
            CKS_EXT_RISE: tick = ci_rise;
            CKS_EXT_FALL: tick = ci_fall;
            CKS_EXT_BOTH: tick = ci_rise | ci_fall;
            default:      tick = 1'b0;
        endcase
    end

    // Compares use the pre-update TCNT and the pre-write TCOR values.
    assign match_a = tick && (tcnt_reg == tcora_reg);
    assign match_b = tick && (tcnt_reg == tcorb_reg);
    assign ovf_evt = tick && (tcnt_reg == '1);
    assign set_vec = {match_b, match_a, ovf_evt};

    always_comb begin
        tcnt_next = tcnt_reg;
        if (wr && addr == ADDR_TCNT)
            tcnt_next = wdata;
        else if (cclr == CCLR_EXT && ri_rise)
            tcnt_next = '0;
        else if ((cclr == CCLR_MATCH_A && match_a) || (cclr == CCLR_MATCH_B && match_b))
            tcnt_next = '0;
        else if (tick)
            tcnt_next = tcnt_reg + 1'b1;
    end

    // Flag i lives at TCSR bit TCSR_OVF+i; it may only be cleared after a
    // TCSR read has observed it set (armed).
    for (gi = 0; gi < 3; gi++) begin : g_flag
        logic flag_reg;
        logic armed_reg;

        always_ff @(posedge clk) begin
            if (rst) begin
                flag_reg  <= 1'b0;
                armed_reg <= 1'b0;
            end else if (set_vec[gi]) begin
                flag_reg  <= 1'b1;
                armed_reg <= 1'b0;
            end else if (wr_tcsr && !wdata[TCSR_OVF+gi] && armed_reg) begin
                flag_reg  <= 1'b0;
                armed_reg <= 1'b0;
            end else if (rd_tcsr && flag_reg) begin
                armed_reg <= 1'b1;
            end
        end

        assign flags[gi] = flag_reg;
    end

    assign tcsr_view = {flags, 1'b0, 2'(osb_reg), 2'(osa_reg)};

    always_comb begin
        rd_sel = '0;
        case (addr)
            ADDR_TCR:   rd_sel = tcr_reg;
            ADDR_TCSR:  rd_sel = BIT_WIDTH'(tcsr_view);
            ADDR_TCORA: rd_sel = tcora_reg;
            ADDR_TCORB: rd_sel = tcorb_reg;
            ADDR_TCNT:  rd_sel = tcnt_reg;
            default:    rd_sel = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt_reg  <= '0;
            tcora_reg <= '1;
            tcorb_reg <= '1;
            tcr_reg   <= '0;
            osa_reg   <= OS_NONE;
            osb_reg   <= OS_NONE;
            tmo_reg   <= 1'b0;
            rdata_reg <= '0;
        end else begin
            tcnt_reg <= tcnt_next;
            tmo_reg  <= tmo_resolve(tmo_reg, match_a, match_b, osa_reg, osb_reg);
            if (rd)
                rdata_reg <= rd_sel;
            if (wr) begin
                case (addr)
                    ADDR_TCR:   tcr_reg <= wdata;
                    ADDR_TCSR: begin
                        osb_reg <= os_e'(wdata[TCSR_OSB_LSB +: 2]);
                        osa_reg <= os_e'(wdata[TCSR_OSA_LSB +: 2]);
                    end
                    ADDR_TCORA: tcora_reg <= wdata;
                    ADDR_TCORB: tcorb_reg <= wdata;
                    default: ;
                endcase
            end
        end
    end

    assign rdata   = rdata_reg;
    assign tmo     = tmo_reg;
    assign irq_cma = flags[TCSR_CMFA-TCSR_OVF] & tcr_reg[TCR_CMIEA];
    assign irq_cmb = flags[TCSR_CMFB-TCSR_OVF] & tcr_reg[TCR_CMIEB];
    assign irq_ovf = flags[0] & tcr_reg[TCR_OVIE];

endmodule

// File: tb/tb_tmr_channel_ctrl.sv
// Bench for tmr_channel_ctrl: directed scenarios with literal expectations plus
// randomized traffic, all outputs compared every cycle against a behavioural model.
module tb_tmr_channel_ctrl;

    logic       clk;
    logic       rst;
    logic [2:0] addr;
    logic       wr;
    logic       rd;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       tmci;
    logic       tmri;
    logic       tmo;
    logic       irq_cma;
    logic       irq_cmb;
    logic       irq_ovf;

    int n_checks = 0;
    int n_err    = 0;

    tmr_channel_ctrl #(.BIT_WIDTH(8), .PRESC_WIDTH(13)) dut (
        .clk     (clk),
        .rst     (rst),
        .addr    (addr),
        .wr      (wr),
        .rd      (rd),
        .wdata   (wdata),
        .rdata   (rdata),
        .tmci    (tmci),
        .tmri    (tmri),
        .tmo     (tmo),
        .irq_cma (irq_cma),
        .irq_cmb (irq_cmb),
        .irq_ovf (irq_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int       m_tcnt, m_tcora, m_tcorb, m_osa, m_osb, m_rdata, m_presc;
    bit [7:0] m_tcr;
    bit       m_flag  [3];   // 0 OVF, 1 CMFA, 2 CMFB
    bit       m_armed [3];
    bit       m_tmo;
    bit [2:0] ci_h, ri_h;    // [0] pin at last edge, [1] one edge earlier, ...
    bit       m_valid = 1'b0;

    function automatic int reg_val(input int a);
        case (a)
            0:       return int'(m_tcr);
            1:       return (m_flag[2] ? 128 : 0) + (m_flag[1] ? 64 : 0) + (m_flag[0] ? 32 : 0)
                            + m_osb * 4 + m_osa;
            2:       return m_tcora;
            3:       return m_tcorb;
            4:       return m_tcnt;
            default: return 0;
        endcase
    endfunction

    initial begin : model
        forever begin : step
            int cks, cclr, act, nt, a;
            bit ci_r, ci_f, ri_r, tick, ma, mb, ov;
            bit setv [3];
            @(posedge clk);
            if (rst) begin
                m_tcnt = 0; m_tcora = 255; m_tcorb = 255; m_tcr = 8'h00;
                m_osa = 0; m_osb = 0; m_rdata = 0; m_presc = 0; m_tmo = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    m_flag[i] = 1'b0;
                    m_armed[i] = 1'b0;
                end
                ci_h = 3'b000; ri_h = 3'b000;
                m_valid = 1'b1;
            end else begin
                a    = int'(addr);
                cks  = int'(m_tcr[2:0]);
                cclr = int'(m_tcr[4:3]);
                ci_r = ci_h[1] && !ci_h[2];
                ci_f = !ci_h[1] && ci_h[2];
                ri_r = ri_h[1] && !ri_h[2];
                case (cks)
                    1:       tick = (m_presc % 8) == 7;
                    2:       tick = (m_presc % 64) == 63;
                    3:       tick = (m_presc % 8192) == 8191;
                    4:       tick = ci_r;
                    5:       tick = ci_f;
                    6:       tick = ci_r || ci_f;
                    default: tick = 1'b0;
                endcase
                ma = tick && (m_tcnt == m_tcora);
                mb = tick && (m_tcnt == m_tcorb);
                ov = tick && (m_tcnt == 255);

                if (rd) m_rdata = reg_val(a);

                setv[0] = ov; setv[1] = ma; setv[2] = mb;
                for (int i = 0; i < 3; i++) begin
                    if (setv[i]) begin
                        m_flag[i] = 1'b1; m_armed[i] = 1'b0;
                    end else if (wr && a == 1 && !wdata[5+i] && m_armed[i]) begin
                        m_flag[i] = 1'b0; m_armed[i] = 1'b0;
                    end else if (rd && a == 1 && m_flag[i]) begin
                        m_armed[i] = 1'b1;
                    end
                end

                if (ma || mb) begin
                    if (ma && mb)
                        act = (m_osa == 3 || m_osb == 3) ? 3 :
                              (m_osa == 2 || m_osb == 2) ? 2 :
                              (m_osa == 1 || m_osb == 1) ? 1 : 0;
                    else
                        act = ma ? m_osa : m_osb;
                    if (act == 1) m_tmo = 1'b0;
                    else if (act == 2) m_tmo = 1'b1;
                    else if (act == 3) m_tmo = !m_tmo;
                end

                nt = m_tcnt;
                if (wr && a == 4) nt = int'(wdata);
                else if (cclr == 3 && ri_r) nt = 0;
                else if (tick && ((cclr == 1 && ma) || (cclr == 2 && mb))) nt = 0;
                else if (tick && m_tcnt == 255) nt = 0;
                else if (tick) nt = m_tcnt + 1;

                if (wr) begin
                    case (a)
                        0: m_tcr = wdata;
                        1: begin m_osb = int'(wdata[3:2]); m_osa = int'(wdata[1:0]); end
                        2: m_tcora = int'(wdata);
                        3: m_tcorb = int'(wdata);
                        default: ;
                    endcase
                end
                m_tcnt = nt;
                m_presc++;
                ci_h = {ci_h[1:0], tmci};
                ri_h = {ri_h[1:0], tmri};
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            if (m_valid) begin
                check("rdata", rdata, m_rdata);
                check("tmo", tmo, m_tmo);
                check("irq_cma", irq_cma, m_flag[1] && m_tcr[6]);
                check("irq_cmb", irq_cmb, m_flag[2] && m_tcr[7]);
                check("irq_ovf", irq_ovf, m_flag[0] && m_tcr[5]);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [7:0] d);
        addr = a; wdata = d; wr = 1'b1;
        @(posedge clk);
        #1;
        wr = 1'b0;
    endtask

    task automatic rd_reg(input logic [2:0] a, output logic [7:0] d);
        addr = a; rd = 1'b1;
        @(posedge clk);
        #1;
        rd = 1'b0;
        d = rdata;
    endtask

    task automatic pulse_ci(input int w);
        tmci = 1'b1;
        wait_cyc(w);
        tmci = 1'b0;
        wait_cyc(w);
    endtask

    initial begin : main
        logic [7:0] d;
        logic       prev;
        int         k;

        rst = 1'b1; wr = 1'b0; rd = 1'b0; addr = 3'd0; wdata = 8'h00;
        tmci = 1'b0; tmri = 1'b0;
        wait_cyc(3);
        rst = 1'b0;

        // reset values
        rd_reg(3'd0, d); check("reset_tcr", d, 8'h00);
        rd_reg(3'd1, d); check("reset_tcsr", d, 8'h00);
        rd_reg(3'd2, d); check("reset_tcora", d, 8'hFF);
        rd_reg(3'd3, d); check("reset_tcorb", d, 8'hFF);
        rd_reg(3'd4, d); check("reset_tcnt", d, 8'h00);
        check("reset_tmo", tmo, 1'b0);

        // clk/8 count, clear on A=3, toggle TMO: period 32 clk
        wr_reg(3'd2, 8'h03);
        wr_reg(3'd1, 8'h03);
        wr_reg(3'd0, 8'h09);
        prev = tmo; k = 0;
        while (tmo === prev && k < 100) begin wait_cyc(1); k++; end
        check("presc_first_toggle_seen", k < 100, 1'b1);
        prev = tmo; k = 0;
        while (tmo === prev && k < 100) begin wait_cyc(1); k++; end
        check("presc_tmo_period", k, 32);
        wr_reg(3'd0, 8'h04);
        rd_reg(3'd1, d); check("presc_tcsr_cmfa", d, 8'h43);
        wr_reg(3'd1, 8'h00);

        // 256 TMCI rising edges from 00: wrap, OVF, armed clear
        wr_reg(3'd4, 8'h00);
        for (int i = 0; i < 256; i++) pulse_ci(2);
        wait_cyc(4);
        rd_reg(3'd4, d); check("ovf_tcnt_wrapped", d, 8'h00);
        wr_reg(3'd1, 8'h00);
        rd_reg(3'd1, d); check("ovf_unarmed_write_no_clear", d, 8'hE0);
        wr_reg(3'd1, 8'h00);
        rd_reg(3'd1, d); check("ovf_armed_clear", d, 8'h00);

        // simultaneous A/B match TMO resolution
        wr_reg(3'd2, 8'h10);
        wr_reg(3'd3, 8'h10);
        wr_reg(3'd1, 8'h05); wr_reg(3'd4, 8'h10); pulse_ci(3);
        check("ab_both_low", tmo, 1'b0);
        wr_reg(3'd1, 8'h09); wr_reg(3'd4, 8'h10); pulse_ci(3);
        check("ab_low_high_gives_high", tmo, 1'b1);
        wr_reg(3'd1, 8'h05); wr_reg(3'd4, 8'h10); pulse_ci(3);
        check("ab_reset_low", tmo, 1'b0);
        wr_reg(3'd1, 8'h0B); wr_reg(3'd4, 8'h10); pulse_ci(3);
        check("ab_toggle_wins", tmo, 1'b1);

        // external TMRI clear with exact latency, then CPU write priority
        wr_reg(3'd0, 8'h1C);
        wr_reg(3'd4, 8'h40);
        wait_cyc(2);
        tmri = 1'b1;
        wait_cyc(2);
        rd_reg(3'd4, d); check("tmri_before_clear", d, 8'h40);
        rd_reg(3'd4, d); check("tmri_cleared", d, 8'h00);
        tmri = 1'b0;
        wait_cyc(4);
        tmri = 1'b1;
        wait_cyc(2);
        wr_reg(3'd4, 8'h55);
        tmri = 1'b0;
        wait_cyc(3);
        rd_reg(3'd4, d); check("tmri_vs_write", d, 8'h55);

        // set/clear race on CMFA
        wr_reg(3'd0, 8'h04);
        rd_reg(3'd1, d);
        wr_reg(3'd1, 8'h00);
        rd_reg(3'd1, d); check("race_flags_cleared", d, 8'h00);
        wr_reg(3'd2, 8'h20);
        wr_reg(3'd4, 8'h20);
        pulse_ci(3);
        rd_reg(3'd1, d); check("race_cmfa_set", d, 8'h40);
        wr_reg(3'd4, 8'h20);
        tmci = 1'b1;
        wait_cyc(2);
        wr_reg(3'd1, 8'h00);
        tmci = 1'b0;
        wait_cyc(3);
        wr_reg(3'd1, 8'h00);
        rd_reg(3'd1, d); check("race_set_wins", d, 8'h40);

        // reset mid-count
        wr_reg(3'd2, 8'hFF);
        wr_reg(3'd1, 8'h02);
        wr_reg(3'd4, 8'hFF);
        wr_reg(3'd0, 8'h24);
        pulse_ci(3);
        wr_reg(3'd4, 8'h7F);
        check("pre_rst_tmo", tmo, 1'b1);
        check("pre_rst_irq_ovf", irq_ovf, 1'b1);
        rst = 1'b1;
        wait_cyc(1);
        rst = 1'b0;
        check("post_rst_tmo", tmo, 1'b0);
        check("post_rst_irq_ovf", irq_ovf, 1'b0);
        rd_reg(3'd1, d); check("post_rst_tcsr", d, 8'h00);
        rd_reg(3'd4, d); check("post_rst_tcnt", d, 8'h00);
        rd_reg(3'd2, d); check("post_rst_tcora", d, 8'hFF);

        // randomized traffic, checked by the model every cycle
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            wr = 1'b0;
            rd = 1'b0;
            rst = ($urandom_range(0, 399) == 0);
            if (r < 15) begin
                wr = 1'b1;
                addr = 3'($urandom_range(0, 7));
                wdata = 8'($urandom);
            end else if (r < 40) begin
                rd = 1'b1;
                addr = 3'($urandom_range(0, 7));
            end
            if ($urandom_range(0, 2) == 0) tmci = !tmci;
            if ($urandom_range(0, 9) == 0) tmri = !tmri;
            wait_cyc(1);
        end
        wr = 1'b0; rd = 1'b0; rst = 1'b0;
        wait_cyc(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
